// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcode map, flag bit positions
// and opcode classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    // Compare-class ops always set flags and never write a result back.
    function automatic logic is_cmp(input alu_op_e op);
        case (op)
            OP_TST, OP_TEQ, OP_CMP, OP_CMN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Logical ops leave C and V untouched.
    function automatic logic is_logic(input alu_op_e op);
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: every arithmetic op is folded onto a single adder
// x + y + ci, with subtraction expressed as x + ~y + carry.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    alu_op_e          op_e_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic             ci_s;
    logic [WIDTH-1:0] logic_res_s;
    logic [WIDTH:0]   sum_s;
    logic             arith_s;

    assign op_e_s = alu_op_e'(op);

    // Select adder operands / carry-in, or the logical result.
    always_comb begin
        x_s         = a;
        y_s         = b;
        ci_s        = 1'b0;
        logic_res_s = {WIDTH{1'b0}};
        case (op_e_s)
            OP_AND, OP_TST: logic_res_s = a & b;
            OP_EOR, OP_TEQ: logic_res_s = a ^ b;
            OP_SUB, OP_CMP: begin
                y_s  = ~b;
                ci_s = 1'b1;
            end
            OP_RSB: begin
                x_s  = b;
                y_s  = ~a;
                ci_s = 1'b1;
            end
            OP_ADD, OP_CMN: ci_s = 1'b0;
            OP_ADC:         ci_s = cin;
            OP_SBC: begin
                y_s  = ~b;
                ci_s = cin;
            end
            OP_RSC: begin
                x_s  = b;
                y_s  = ~a;
                ci_s = cin;
            end
            OP_ORR:  logic_res_s = a | b;
            OP_MOV:  logic_res_s = b;
            OP_BIC:  logic_res_s = a & ~b;
            OP_MVN:  logic_res_s = ~b;
            default: logic_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign arith_s = !is_logic(op_e_s);
    assign sum_s   = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, ci_s};
    assign result  = arith_s ? sum_s[WIDTH-1:0] : logic_res_s;
    assign n       = result[WIDTH-1];
    assign z       = (result == {WIDTH{1'b0}});
    assign c       = arith_s ? sum_s[WIDTH] : cin;
    // Overflow: both adder inputs share a sign that the sum does not.
    assign v       = arith_s && (x_s[WIDTH-1] == y_s[WIDTH-1])
                             && (sum_s[WIDTH-1] != x_s[WIDTH-1]);

endmodule

// File: rtl/execute_pipe.sv
// Two-stage ALU execute stage: forwarded operand capture (S1), ALU, result
// register (S2), valid/ready handshake and the architectural NZCV register.
module execute_pipe
    import alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         NUM_FWD    = 2,
    parameter logic [3:0] NZCV_RESET = 4'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_op,
    input  logic                         in_s,
    input  logic [WIDTH-1:0]             in_opr1,
    input  logic [WIDTH-1:0]             in_opr2,
    input  logic [$clog2(NUM_FWD+1)-1:0] in_fwd1_sel,
    input  logic [$clog2(NUM_FWD+1)-1:0] in_fwd2_sel,
    input  logic [NUM_FWD*WIDTH-1:0]     fwd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic                         out_wr_en,
    output logic [3:0]                   out_nzcv
);

    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic             s1_valid_r;
    alu_op_e          s1_op_r;
    logic             s1_s_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             wr_en_r;
    logic [3:0]       nzcv_r;

    logic             s2_adv_s;
    logic             in_fire_s;
    logic [WIDTH-1:0] fwd_a_s;
    logic [WIDTH-1:0] fwd_b_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_n_s;
    logic             alu_z_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [3:0]       nzcv_next_s;
    logic             flag_upd_s;

    // Select 0 = register operand, k = forward slice k-1, anything above NUM_FWD = zero.
    function automatic logic [WIDTH-1:0] fwd_pick(
        input logic [SEL_W-1:0]         sel,
        input logic [WIDTH-1:0]         opr,
        input logic [NUM_FWD*WIDTH-1:0] fwd
    );
        logic [WIDTH-1:0] val;
        val = (sel == {SEL_W{1'b0}}) ? opr : {WIDTH{1'b0}};
        for (int k = 1; k <= NUM_FWD; k++) begin
            val = (int'(sel) == k) ? fwd[(k-1)*WIDTH +: WIDTH] : val;
        end
        return val;
    endfunction

    assign s2_adv_s  = s1_valid_r && (!s2_valid_r || out_ready);
    assign in_ready  = !s1_valid_r || s2_adv_s;
    assign in_fire_s = in_valid && in_ready;
    assign fwd_a_s   = fwd_pick(in_fwd1_sel, in_opr1, fwd_data);
    assign fwd_b_s   = fwd_pick(in_fwd2_sel, in_opr2, fwd_data);

    // Carry-in comes straight from the flag register, so a flag-setting op
    // leaving S1 on the same edge is already visible to the next op.
    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .op     (s1_op_r),
        .cin    (nzcv_r[NZCV_C]),
        .result (alu_res_s),
        .n      (alu_n_s),
        .z      (alu_z_s),
        .c      (alu_c_s),
        .v      (alu_v_s)
    );

    assign flag_upd_s = is_cmp(s1_op_r) || s1_s_r;

    // Next flag value; logical ops preserve C and V.
    always_comb begin
        nzcv_next_s         = nzcv_r;
        nzcv_next_s[NZCV_N] = alu_n_s;
        nzcv_next_s[NZCV_Z] = alu_z_s;
        if (is_logic(s1_op_r)) begin
            nzcv_next_s[NZCV_C] = nzcv_r[NZCV_C];
            nzcv_next_s[NZCV_V] = nzcv_r[NZCV_V];
        end else begin
            nzcv_next_s[NZCV_C] = alu_c_s;
            nzcv_next_s[NZCV_V] = alu_v_s;
        end
    end

    // Stage 1: operand register with forwarding applied at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= OP_AND;
            s1_s_r     <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= alu_op_e'(in_op);
            s1_s_r     <= in_s;
            s1_a_r     <= fwd_a_s;
            s1_b_r     <= fwd_b_s;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: result register and flag commit; a flush discards the advancing op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            wr_en_r    <= 1'b0;
            nzcv_r     <= NZCV_RESET;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= 1'b1;
            result_r   <= alu_res_s;
            wr_en_r    <= !is_cmp(s1_op_r);
            if (flag_upd_s) begin
                nzcv_r <= nzcv_next_s;
            end
        end else if (out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    assign out_valid  = s2_valid_r;
    assign out_result = result_r;
    assign out_wr_en  = wr_en_r;
    assign out_nzcv   = nzcv_r;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed scenarios followed by random traffic, all
// checked against an in-order arithmetic reference model with a result queue.
module tb_execute_pipe;

    localparam logic [3:0] AND_ = 4'h0, EOR_ = 4'h1, SUB_ = 4'h2, ADD_ = 4'h4, ADC_ = 4'h5;
    localparam logic [3:0] CMP_ = 4'hA, ORR_ = 4'hC, MOV_ = 4'hD;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'h0;
    logic        in_s = 1'b0;
    logic [31:0] in_opr1 = 32'h0;
    logic [31:0] in_opr2 = 32'h0;
    logic [1:0]  in_fwd1_sel = 2'd0;
    logic [1:0]  in_fwd2_sel = 2'd0;
    logic [63:0] fwd_data = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_wr_en;
    logic [3:0]  out_nzcv;

    typedef struct {
        logic [31:0] res;
        logic        wr;
        logic [3:0]  fl;
    } exp_t;

    exp_t       q[$];
    logic [3:0] ref_fl = 4'h0;
    int         n_checks = 0;
    int         n_errors = 0;

    execute_pipe #(.WIDTH(32), .NUM_FWD(2), .NZCV_RESET(4'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_s        (in_s),
        .in_opr1     (in_opr1),
        .in_opr2     (in_opr2),
        .in_fwd1_sel (in_fwd1_sel),
        .in_fwd2_sel (in_fwd2_sel),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_wr_en   (out_wr_en),
        .out_nzcv    (out_nzcv)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] opr,
                                         input logic [63:0] fwd);
        case (sel)
            2'd0:    return opr;
            2'd1:    return fwd[31:0];
            2'd2:    return fwd[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // Reference: unsigned/signed arithmetic on 64-bit integers, C as "no borrow" for subtracts.
    function automatic void ref_exec(input logic [3:0] op, input logic s, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] fin,
                                     output logic [31:0] res, output logic wr,
                                     output logic [3:0] fout);
        longint ux, uy, sx, sy, ur, sr;
        logic [31:0] x, y;
        int kind;
        logic ci, nc, nv, cmp;
        ci = fin[1]; kind = 0; x = a; y = b; res = 32'h0;
        ur = 0; sr = 0;
        case (op)
            4'h0, 4'h8: res = a & b;
            4'h1, 4'h9: res = a ^ b;
            4'h2, 4'hA: begin kind = 2; ci = 1'b1; end
            4'h3:       begin kind = 2; x = b; y = a; ci = 1'b1; end
            4'h4, 4'hB: begin kind = 1; ci = 1'b0; end
            4'h5:       kind = 1;
            4'h6:       kind = 2;
            4'h7:       begin kind = 2; x = b; y = a; end
            4'hC:       res = a | b;
            4'hD:       res = b;
            4'hE:       res = a & ~b;
            default:    res = ~b;
        endcase
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        nc = fin[1];
        nv = fin[0];
        if (kind == 1) begin
            ur = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
            nc = (ur > 64'sd4294967295);
        end else if (kind == 2) begin
            ur = ux - uy - (64'sd1 - longint'(ci));
            sr = sx - sy - (64'sd1 - longint'(ci));
            nc = (ur >= 0);
        end
        if (kind != 0) begin
            res = ur[31:0];
            nv  = (sr > SMAX) || (sr < SMIN);
        end
        cmp  = (op >= 4'h8) && (op <= 4'hB);
        wr   = !cmp;
        fout = (cmp || s) ? {res[31], (res == 32'h0), nc, nv} : fin;
    endfunction

    // One clock: check any output transfer, model any input transfer, advance to next negedge.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        acc = 1'b0;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else if (out_ready) begin
                chk("sb_result", out_result, q[0].res);
                chk("sb_wr_en", out_wr_en, q[0].wr);
                chk("sb_nzcv", out_nzcv, q[0].fl);
                void'(q.pop_front());
            end
        end
        if (in_valid && (in_ready === 1'b1)) begin
            acc = 1'b1;
            if (!flush) begin
                ref_exec(in_op, in_s, pick(in_fwd1_sel, in_opr1, fwd_data),
                         pick(in_fwd2_sel, in_opr2, fwd_data), ref_fl, e.res, e.wr, e.fl);
                ref_fl = e.fl;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [63:0] fwd);
        in_valid = 1'b1; in_op = op; in_s = s; in_opr1 = a; in_opr2 = b;
        in_fwd1_sel = s1; in_fwd2_sel = s2; fwd_data = fwd;
    endtask

    // Present one op and wait (bounded) for it to be accepted; in_valid stays high.
    task automatic send(input logic [3:0] op, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [63:0] fwd);
        bit acc;
        int n;
        drive(op, s, a, b, s1, s2, fwd);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            tick(acc);
            n++;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            tick(acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    // Single op through an empty pipe with explicit latency and value checks.
    task automatic run1(input string tag, input logic [3:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [63:0] fwd, input logic [31:0] er,
                        input logic ew, input logic [3:0] ef);
        bit acc;
        send(op, s, a, b, s1, s2, fwd);
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick(acc);
        #1;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, out_result, er);
        chk({tag, "_wr_en"}, out_wr_en, ew);
        chk({tag, "_nzcv"}, out_nzcv, ef);
        tick(acc);
    endtask

    initial begin
        bit acc;
        logic [3:0] saved;
        logic [31:0] ra, rb;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_wr_en", out_wr_en, 1'b0);
        chk("rst_out_nzcv", out_nzcv, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        run1("adds_wrap", ADD_, 1'b1, 32'hFFFFFFFF, 32'h1, 2'd0, 2'd0, 64'h0, 32'h0, 1'b1, 4'b0110);

        // ADDS overflow followed back-to-back by ADC that must see C=0.
        send(ADD_, 1'b1, 32'h7FFFFFFF, 32'h1, 2'd0, 2'd0, 64'h0);
        send(ADC_, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 64'h0);
        in_valid = 1'b0;
        #1;
        chk("adds_ovf_result", out_result, 32'h80000000);
        chk("adds_ovf_nzcv", out_nzcv, 4'b1001);
        tick(acc);
        #1;
        chk("adc_chain_result", out_result, 32'h0);
        chk("adc_chain_nzcv", out_nzcv, 4'b1001);
        tick(acc);

        run1("cmp_eq", CMP_, 1'b0, 32'd5, 32'd5, 2'd0, 2'd0, 64'h0, 32'h0, 1'b0, 4'b0110);
        run1("cmp_lt", CMP_, 1'b0, 32'd3, 32'd5, 2'd0, 2'd0, 64'h0, 32'hFFFFFFFE, 1'b0, 4'b1000);
        run1("orr_nos", ORR_, 1'b0, 32'hF0, 32'h0F, 2'd0, 2'd0, 64'h0, 32'hFF, 1'b1, 4'b1000);
        run1("fwd2_slice1", SUB_, 1'b0, 32'h30, 32'hDEAD, 2'd0, 2'd2, {32'h10, 32'h999},
             32'h20, 1'b1, 4'b1000);
        run1("fwd2_oob", SUB_, 1'b0, 32'h30, 32'hDEAD, 2'd0, 2'd3, {32'h10, 32'h999},
             32'h30, 1'b1, 4'b1000);
        run1("fwd1_slice0", ADD_, 1'b0, 32'hBEEF, 32'h5, 2'd1, 2'd0, {32'h10, 32'h100},
             32'h105, 1'b1, 4'b1000);

        // Stall: three ops issued while downstream is blocked.
        out_ready = 1'b0;
        send(ADD_, 1'b0, 32'd1, 32'd2, 2'd0, 2'd0, 64'h0);
        send(ADD_, 1'b0, 32'd3, 32'd4, 2'd0, 2'd0, 64'h0);
        drive(EOR_, 1'b0, 32'hF0, 32'hFF, 2'd0, 2'd0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_hold_result", out_result, 32'd3);
            tick(acc);
            chk("stall_no_accept", acc, 1'b0);
        end
        out_ready = 1'b1;
        send(EOR_, 1'b0, 32'hF0, 32'hFF, 2'd0, 2'd0, 64'h0);
        drain();

        // Flush with both stages full and downstream blocked; input presented too.
        out_ready = 1'b0;
        send(ADD_, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 2'd0, 64'h0);
        send(CMP_, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 64'h0);
        drive(MOV_, 1'b1, 32'h0, 32'h0, 2'd0, 2'd0, 64'h0);
        saved = q[0].fl;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush1_out_valid", out_valid, 1'b0);
        chk("flush1_nzcv", out_nzcv, 4'b1010);
        chk("flush1_in_ready", in_ready, 1'b1);
        q.delete();
        ref_fl = saved;
        out_ready = 1'b1;
        run1("post_flush", MOV_, 1'b0, 32'h0, 32'h55, 2'd0, 2'd0, 64'h0, 32'h55, 1'b1, 4'b1010);

        // Flush while the S1 op is advancing: it must not commit flags.
        send(ADD_, 1'b1, 32'd1, 32'd1, 2'd0, 2'd0, 64'h0);
        send(CMP_, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 64'h0);
        in_valid = 1'b0;
        saved = q[0].fl;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        #1;
        chk("flush2_out_valid", out_valid, 1'b0);
        chk("flush2_nzcv", out_nzcv, 4'b0000);
        q.delete();
        ref_fl = saved;

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        send(CMP_, 1'b0, 32'd3, 32'd5, 2'd0, 2'd0, 64'h0);
        send(MOV_, 1'b0, 32'h0, 32'h9, 2'd0, 2'd0, 64'h0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_result", out_result, 32'h0);
        chk("midrst_out_wr_en", out_wr_en, 1'b0);
        chk("midrst_out_nzcv", out_nzcv, 4'h0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        ref_fl = 4'h0;

        // Random traffic with random back-pressure.
        for (int i = 0; i < 900; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                case ($urandom_range(0, 4))
                    0:       ra = 32'hFFFFFFFF;
                    1:       ra = 32'h7FFFFFFF;
                    2:       ra = 32'h80000000;
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 4))
                    0:       rb = 32'h0;
                    1:       rb = 32'h1;
                    2:       rb = 32'h80000000;
                    default: rb = $urandom;
                endcase
                drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra, rb,
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      {32'($urandom), 32'($urandom)});
            end
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
